// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one single-port DRAM (1-cycle read latency) among NUM_CORES cores.
// Grants, DRAM command and read-valid are all registered; rdata is a passthrough of dram_q.
module dram_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        we,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    input  logic [NUM_CORES*DATA_W-1:0] wdata,
    output logic [NUM_CORES-1:0]        gnt,
    output logic [NUM_CORES-1:0]        rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic [ADDR_W-1:0]           dram_addr,
    output logic [DATA_W-1:0]           dram_data,
    output logic                        dram_wren,
    input  logic [DATA_W-1:0]           dram_q,
    output logic [15:0]                 grant_cnt,
    output logic                        state_o
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       last_q;
    logic [NUM_CORES-1:0]   gnt_q;
    logic [NUM_CORES-1:0]   rvalid_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      data_q;
    logic                   wren_q;
    logic [15:0]            cnt_q;

    logic [NUM_CORES-1:0]   eligible;
    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;
    logic [NUM_CORES-1:0]   win_onehot;
    logic [ADDR_W-1:0]      win_addr;
    logic [DATA_W-1:0]      win_data;
    logic                   win_we;

    // Request handshake: a core holds req/we/addr/wdata until it sees its gnt pulse.
    // Its req is still high in that gnt cycle, so a core granted now is masked out.
    assign eligible = req & ~gnt_q;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            if (!win_found && eligible[IDX_W'((int'(last_q) + k) % NUM_CORES)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'((int'(last_q) + k) % NUM_CORES);
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        win_addr   = '0;
        win_data   = '0;
        win_we     = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (win_found && (IDX_W'(i) == win_idx)) begin
                win_onehot[i] = 1'b1;
                win_addr      = addr[i*ADDR_W +: ADDR_W];
                win_data      = wdata[i*DATA_W +: DATA_W];
                win_we        = we[i];
            end
        end
    end

    always_comb begin
        state_d = IDLE;
        if (win_found) begin
            state_d = GRANT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= IDX_W'(NUM_CORES - 1);
            gnt_q    <= '0;
            rvalid_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            wren_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= win_onehot;
            wren_q   <= win_found & win_we;
            // Fixed 1-cycle DRAM latency: a read granted now returns data next cycle.
            rvalid_q <= wren_q ? '0 : gnt_q;
            if (win_found) begin
                last_q <= win_idx;
                addr_q <= win_addr;
                data_q <= win_data;
                if (cnt_q != CNT_MAX) begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end
        end
    end

    assign gnt       = gnt_q;
    assign rvalid    = rvalid_q;
    assign rdata     = dram_q;
    assign dram_addr = addr_q;
    assign dram_data = data_q;
    assign dram_wren = wren_q;
    assign grant_cnt = cnt_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios plus random traffic against a
// transaction-level model (round-robin pick, memory array, read-data queue).
module tb_dram_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;
    logic [AW-1:0]   dram_addr;
    logic [DW-1:0]   dram_data;
    logic            dram_wren;
    logic [DW-1:0]   dram_q;
    logic [15:0]     grant_cnt;
    logic            state_o;

    int n_checks = 0;
    int n_fail   = 0;

    dram_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .dram_addr(dram_addr),
        .dram_data(dram_data), .dram_wren(dram_wren), .dram_q(dram_q),
        .grant_cnt(grant_cnt), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // ---------------- DRAM environment ----------------
    logic [DW-1:0] env_mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] mem_init(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        dram_q <= env_mem.exists(dram_addr) ? env_mem[dram_addr] : mem_init(dram_addr);
        if (dram_wren) env_mem[dram_addr] = dram_data;
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] exp_mem [logic [AW-1:0]];
    logic [DW-1:0] exp_q[$];
    int            m_last, m_prev, m_cnt;
    logic          m_prev_we;
    logic [N-1:0]  e_gnt, e_rvalid;
    logic          e_wren, e_state;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data, e_rdata;

    task automatic model_reset();
        m_last = N - 1; m_prev = -1; m_prev_we = 1'b0; m_cnt = 0;
        e_gnt = '0; e_rvalid = '0; e_wren = 1'b0; e_state = 1'b0;
        e_addr = '0; e_data = '0; e_rdata = '0;
        exp_q.delete();
    endtask

    task automatic predict();
        int w;
        w = -1;
        e_rvalid = '0;
        if (m_prev >= 0 && !m_prev_we) begin
            e_rvalid[m_prev] = 1'b1;
            if (exp_q.size() > 0) e_rdata = exp_q.pop_front();
        end
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (w < 0 && req[c] && c != m_prev) w = c;
        end
        e_gnt = '0;
        e_wren = 1'b0;
        if (w >= 0) begin
            e_gnt[w] = 1'b1;
            e_wren   = we[w];
            e_addr   = addr[w*AW +: AW];
            e_data   = wdata[w*DW +: DW];
            if (we[w]) exp_mem[e_addr] = e_data;
            else exp_q.push_back(exp_mem.exists(e_addr) ? exp_mem[e_addr] : mem_init(e_addr));
            m_last = w;
            if (m_cnt < 65535) m_cnt++;
        end
        m_prev    = w;
        m_prev_we = (w >= 0) ? we[w] : 1'b0;
        e_state   = (w >= 0);
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("rvalid", 32'(rvalid), 32'(e_rvalid));
        chk("dram_wren", 32'(dram_wren), 32'(e_wren));
        chk("dram_addr", 32'(dram_addr), 32'(e_addr));
        chk("dram_data", 32'(dram_data), 32'(e_data));
        chk("grant_cnt", 32'(grant_cnt), 32'(m_cnt));
        chk("state", 32'(state_o), 32'(e_state));
        if (e_rvalid != '0) chk("rdata", 32'(rdata), 32'(e_rdata));
    endtask

    // One clock: model consumes the inputs driven at the last negedge, DUT clocks, outputs compared.
    task automatic cycle();
        if (rst) model_reset();
        else predict();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    // ---------------- drivers ----------------
    logic c_pend [N];

    task automatic set_core(input int i, input logic r, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i] = r;
        we[i]  = w;
        addr[i*AW +: AW] = a;
        wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            set_core(i, 1'b0, 1'b0, '0, '0);
            c_pend[i] = 1'b0;
        end
    endtask

    // Random cores: drop a request once granted, start a new one with probability pct.
    task automatic drive(input int pct);
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) c_pend[i] = 1'b0;
            if (!c_pend[i] && $urandom_range(0, 99) < pct) begin
                c_pend[i] = 1'b1;
                set_core(i, 1'b1, 1'($urandom_range(0, 1)),
                         AW'($urandom_range(0, 15)), DW'($urandom_range(0, 255)));
            end
            req[i] = c_pend[i];
        end
    endtask

    task automatic do_reset();
        clear_all();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_all();
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        chk("rst_gnt", 32'(gnt), 32'h0);
        rst = 1'b0;

        // single read by core 2
        env_mem[16'h0010] = 8'hA5;
        exp_mem[16'h0010] = 8'hA5;
        set_core(2, 1'b1, 1'b0, 16'h0010, 8'h00);
        cycle();
        chk("rd_gnt", 32'(gnt), 32'h4);
        chk("rd_wren", 32'(dram_wren), 32'h0);
        set_core(2, 1'b0, 1'b0, 16'h0010, 8'h00);
        cycle();
        chk("rd_rvalid", 32'(rvalid), 32'h4);
        chk("rd_rdata", 32'(rdata), 32'hA5);
        cycle();

        // contention from reset
        do_reset();
        for (int i = 0; i < N; i++) set_core(i, 1'b1, 1'b0, AW'(i), 8'h00);
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("contend_gnt", 32'(gnt), 32'(1 << (k % N)));
        end
        clear_all();
        repeat (2) cycle();

        // write by core 1, then read back by core 0
        set_core(1, 1'b1, 1'b1, 16'h0100, 8'h3C);
        cycle();
        chk("wr_gnt", 32'(gnt), 32'h2);
        chk("wr_wren", 32'(dram_wren), 32'h1);
        set_core(1, 1'b0, 1'b0, '0, '0);
        set_core(0, 1'b1, 1'b0, 16'h0100, 8'h00);
        cycle();
        chk("rb_gnt", 32'(gnt), 32'h1);
        chk("wr_no_rvalid", 32'(rvalid), 32'h0);
        chk("rb_wren", 32'(dram_wren), 32'h0);
        set_core(0, 1'b0, 1'b0, '0, '0);
        cycle();
        chk("rb_rvalid", 32'(rvalid), 32'h1);
        chk("rb_rdata", 32'(rdata), 32'h3C);

        // fairness after idle
        set_core(3, 1'b1, 1'b0, 16'h0020, 8'h00);
        cycle();
        chk("fair_g3", 32'(gnt), 32'h8);
        set_core(3, 1'b0, 1'b0, '0, '0);
        repeat (2) cycle();
        set_core(0, 1'b1, 1'b0, 16'h0021, 8'h00);
        set_core(3, 1'b1, 1'b0, 16'h0022, 8'h00);
        cycle();
        chk("fair_g0", 32'(gnt), 32'h1);
        set_core(0, 1'b0, 1'b0, '0, '0);
        cycle();
        chk("fair_g3b", 32'(gnt), 32'h8);
        clear_all();
        repeat (2) cycle();

        // reset during a read grant
        set_core(2, 1'b1, 1'b0, 16'h0030, 8'h00);
        cycle();
        chk("mr_gnt", 32'(gnt), 32'h4);
        #1 rst = 1'b1;
        #1;
        chk("mr_gnt_clr", 32'(gnt), 32'h0);
        chk("mr_wren_clr", 32'(dram_wren), 32'h0);
        chk("mr_rvalid", 32'(rvalid), 32'h0);
        chk("mr_cnt", 32'(grant_cnt), 32'h0);
        clear_all();
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) set_core(i, 1'b1, 1'b0, AW'(16'h0040 + i), 8'h00);
        cycle();
        chk("mr_first", 32'(gnt), 32'h1);
        chk("mr_no_rvalid", 32'(rvalid), 32'h0);
        clear_all();
        repeat (3) cycle();

        // random traffic
        do_reset();
        repeat (1000) begin
            drive(35);
            cycle();
        end
        clear_all();
        repeat (3) cycle();

        // grant counter saturation
        do_reset();
        repeat (70000) begin
            drive(100);
            cycle();
        end
        chk("sat_cnt", 32'(grant_cnt), 32'hFFFF);
        repeat (5) begin
            drive(100);
            cycle();
        end
        chk("sat_hold", 32'(grant_cnt), 32'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, meaning the number of requesting cores (2..8).
REQ-002 SHALL have parameter ADDR_W, default 16, meaning the DRAM address width.
REQ-003 SHALL have parameter DATA_W, default 8, meaning the DRAM data width.
REQ-004 SHALL have port clk  input  1  meaning the single system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  meaning reset; asynchronous, active-high.
REQ-006 SHALL have port req  input  NUM_CORES  meaning per-core access request, level.
REQ-007 SHALL have port we  input  NUM_CORES  meaning per-core write enable, qualified by req.
REQ-008 SHALL have port addr  input  NUM_CORES*ADDR_W  meaning per-core address, with core i at bits [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port wdata  input  NUM_CORES*DATA_W  meaning per-core write data, packed the same way as addr.
REQ-010 SHALL have port gnt  output  NUM_CORES  meaning one-hot grant pulse.
REQ-011 SHALL have port rvalid  output  NUM_CORES  meaning one-hot read-data-valid pulse.
REQ-012 SHALL have port rdata  output  DATA_W  meaning read data, shared by all cores.
REQ-013 SHALL have port dram_addr  output  ADDR_W  meaning the DRAM address.
REQ-014 SHALL have port dram_data  output  DATA_W  meaning the DRAM write data.
REQ-015 SHALL have port dram_wren  output  1  meaning the DRAM write enable.
REQ-016 SHALL have port dram_q  input  DATA_W  meaning DRAM read data, valid the cycle after the address is presented.
REQ-017 SHALL have port grant_cnt  output  16  meaning the total number of grants issued, saturating.

Function
REQ-018 SHALL sample req in cycle t, select a winner, and register gnt, dram_addr, dram_data and dram_wren so all four are presented together in cycle t+1.
REQ-019 SHALL assert at most one gnt bit per cycle, as a single-cycle pulse.
REQ-020 SHALL use round-robin arbitration: priority order starts at last_granted+1 modulo NUM_CORES and wraps.
REQ-021 SHALL exclude a core whose gnt bit is high in the current cycle from arbitration in that cycle, so its still-held req is not double-granted.
REQ-022 SHALL allow back-to-back grants to different cores every cycle (fully pipelined).
REQ-023 SHALL limit any single core to at most one grant per two cycles.
REQ-024 SHALL drive dram_wren = we[winner] in the grant cycle, and 0 in any cycle without a grant.
REQ-025 SHALL hold dram_addr and dram_data at their last values when there is no grant.
REQ-026 SHALL, for a read grant to core i in cycle t+1, assert rvalid[i] in cycle t+2 with rdata = dram_q.
REQ-027 SHALL never assert rvalid for a write grant.
REQ-028 SHALL return read responses strictly in grant order, which is inherent because latency is fixed at 1.
REQ-029 SHALL drive rdata as dram_q passthrough; it is don't-care when rvalid = 0.
REQ-030 SHALL require each core to hold req, we, addr and wdata stable until it observes gnt, then deassert or re-present a new request the next cycle.
REQ-031 SHALL ignore we, addr and wdata of non-requesting cores.
REQ-032 SHALL leave last_granted unchanged in a cycle with no requests.
REQ-033 SHALL increment grant_cnt by 1 per grant and saturate at 16'hFFFF without wrapping.
REQ-034 SHALL implement the arbiter state as IDLE (no grant issued last cycle) and GRANT (grant issued last cycle); transitions depend only on whether any eligible req is present.

Reset
REQ-035 SHALL, while rst = 1, drive gnt = 0, rvalid = 0, dram_wren = 0, dram_addr = 0, dram_data = 0, grant_cnt = 0, state = IDLE and last_granted = NUM_CORES-1, so core 0 wins first.
REQ-036 SHALL apply reset asynchronously, including mid-transaction: a pending read response is discarded and no rvalid is issued after rst deasserts.
REQ-037 SHALL perform its first arbitration on the first rising clk edge after rst deasserts.

Verification
REQ-038 Single read: core 2 reads addr 16'h0010 with DRAM holding 8'hA5 -> gnt = 4'b0100 one cycle after req, rvalid = 4'b0100 and rdata = 8'hA5 the next cycle, dram_wren = 0.
REQ-039 Contention: all 4 cores request continuously from reset -> grants follow the order 0,1,2,3,0,... with one grant per cycle and no core granted in two consecutive cycles.
REQ-040 Write then read: core 1 writes 8'h3C to 16'h0100, then core 0 reads 16'h0100 -> dram_wren = 1 only in core 1's grant cycle, core 0's rvalid carries rdata = 8'h3C, no rvalid for the write.
REQ-041 Fairness after idle: core 3 is granted, then requests stop, then cores 0 and 3 request together -> core 0 is granted first.
REQ-042 Reset mid-read: assert rst in the grant cycle of a read -> gnt and dram_wren clear immediately, rvalid stays 0, grant_cnt = 0, and the next grant after release goes to core 0.
REQ-043 Saturation: force 70000 grants -> grant_cnt = 16'hFFFF and stays there.
